perceptron_sweep_controller: RTL and testbench
==============================================

Name: perceptron_sweep_controller

Overview:
- Upstream driver and result collector for the 2-input, 13-weight perceptron stage.
- Accepts a 13-bit weight vector serially over a valid/ready bit stream into a shadow register.
- On start, commits the weights to the perceptron, steps x through all four input combinations, waits a settle interval for each, and samples the perceptron's p output.
- Returns the 4-entry truth table with a one-cycle done pulse.

Parameters:
- WEIGHT_W, 13, number of weight bits driven to the perceptron.
- SETTLE_CYCLES, 1, extra cycles x is held before p_in is sampled. Legal range is 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wbit_valid  input  1  serial weight bit is present.
- wbit_data  input  1  serial weight bit, LSB (weight[0]) first.
- wbit_ready  output  1  controller can accept a weight bit.
- start  input  1  request a sweep; sampled only in IDLE.
- busy  output  1  high in SWEEP and DONE.
- done  output  1  one-cycle pulse when the truth table is valid.
- err  output  1  one-cycle pulse when start is rejected.
- x  output  2  input vector driven to the perceptron.
- weight  output  WEIGHT_W  committed weight vector driven to the perceptron.
- p_in  input  1  perceptron p output, treated as combinational in x and weight.
- truth  output  4  truth[i] = p sampled with x == i.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, wbit_ready=1, busy=0, done=0, err=0, x=0, weight=0, truth=0, shadow=0, bit counter=0, loaded=0.
- States: IDLE, LOAD, SWEEP, DONE.
- Handshake: a bit transfers on any edge with wbit_valid && wbit_ready. wbit_ready=1 in IDLE and LOAD, 0 in SWEEP and DONE.
- IDLE to LOAD: taken on a transfer.
  - The transferred bit is written to shadow[0].
  - The bit counter is set to 1.
  - loaded is cleared.
- LOAD:
  - Each transfer writes shadow[counter] and increments the counter.
  - The transfer with counter==WEIGHT_W-1 sets loaded=1, clears the counter and returns to IDLE.
  - Cycles with no transfer hold state; there is no timeout.
  - start in LOAD pulses err for one cycle and is otherwise ignored.
- IDLE with start=1 and loaded=1, and no simultaneous bit transfer: start is accepted.
  - On that edge: weight<=shadow, truth<=0, x<=0, settle counter<=0, state<=SWEEP.
  - start and a transfer on the same edge: the transfer wins, start pulses err and the FSM enters LOAD.
- IDLE with start=1 and loaded=0: err pulses for one cycle and the FSM stays in IDLE.
- SWEEP:
  - x is held for SETTLE_CYCLES+1 cycles.
  - On the edge where settle counter==SETTLE_CYCLES, truth[x]<=p_in, settle counter<=0, and x increments.
  - After truth[3] is sampled, x<=0 and state<=DONE.
  - start is ignored in SWEEP and DONE; no err.
- DONE: done=1 for exactly one cycle, then IDLE.
  - truth and weight hold until the next accepted start.
  - loaded stays 1, so the same weights can be re-swept without reloading.
- Latency: start is sampled at edge 0 and done is high after edge 4*(SETTLE_CYCLES+1)+1. With the default this is edge 9.
- Shadow independence: shadow may be reloaded after DONE without disturbing the weight output until the next accepted start.
- Reset mid-LOAD or mid-SWEEP: everything returns to reset values, including loaded=0 and truth=0. A partial load is discarded.
- Widths: the bit counter is ceil(log2(WEIGHT_W)) bits and the settle counter is 4 bits. Neither wraps except as specified above.

Test Plan:
- Load 13'h1A5B LSB-first with wbit_valid held high, then start. Expect weight=13'h1A5B from the edge after start and busy high. With a stub p_in=x[1]&x[0], expect truth=4'b1000 and done high after edge 9.
- Start with no weights loaded since reset: expect err high for exactly one cycle, busy=0, and truth and weight unchanged at 0.
- Load 6 bits, assert rst for one cycle, then start: expect err; the partial load is discarded and loaded=0.
- Set SETTLE_CYCLES=3 and drive a stub p_in that toggles combinationally with x (p_in=x[0]^x[1]):
  - x must hold each value for 4 cycles.
  - Expect truth=4'b0110 and done after edge 17.
- Random gaps on wbit_valid during the load:
  - Expect exactly 13 transfers.
  - wbit_ready must be 0 throughout SWEEP.
  - A bit offered during SWEEP is not consumed.
- Same-edge start and bit transfer in IDLE: expect err, entry into LOAD, and that bit stored as shadow[0].
- After a completed sweep, reload 13'h0000 without start: expect the weight output to stay 13'h1A5B and truth to be unchanged. After start, expect weight=0.

Source files
------------

// File: rtl/perceptron_sweep_controller.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_sweep_controller
//  Purpose  : Serially loads a weight vector into a shadow register, then on
//             start commits it, steps x through 0..3 with a settle interval,
//             samples the perceptron output and returns a 4-entry truth table.
//  Revision : 1.0 - initial release
// ============================================================================
module perceptron_sweep_controller #(
  parameter int WEIGHT_W      = 13,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wbit_valid,
  input  logic                wbit_data,
  output logic                wbit_ready,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          x,
  output logic [WEIGHT_W-1:0] weight,
  input  logic                p_in,
  output logic [3:0]          truth
);

  localparam int                CNT_W       = (WEIGHT_W > 1) ? $clog2(WEIGHT_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WEIGHT_W - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic [WEIGHT_W-1:0] shadow_q, shadow_d;
  logic [WEIGHT_W-1:0] weight_q, weight_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                loaded_q, loaded_d;
  logic [3:0]          settle_q, settle_d;
  logic [1:0]          x_q,      x_d;
  logic [3:0]          truth_q,  truth_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;
  logic                w_xfer;

  assign wbit_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy       = (state_q == S_SWEEP) || (state_q == S_DONE);
  assign w_xfer     = wbit_valid && wbit_ready;
  assign done       = done_q;
  assign err        = err_q;
  assign x          = x_q;
  assign weight     = weight_q;
  assign truth      = truth_q;

  // State and datapath registers; synchronous reset to the idle, unloaded state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      weight_q  <= '0;
      bit_cnt_q <= '0;
      loaded_q  <= 1'b0;
      settle_q  <= 4'd0;
      x_q       <= 2'd0;
      truth_q   <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      weight_q  <= weight_d;
      bit_cnt_q <= bit_cnt_d;
      loaded_q  <= loaded_d;
      settle_q  <= settle_d;
      x_q       <= x_d;
      truth_q   <= truth_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: serial load, start arbitration, settle-timed sweep.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    weight_d  = weight_q;
    bit_cnt_d = bit_cnt_q;
    loaded_d  = loaded_q;
    settle_d  = settle_q;
    x_d       = x_q;
    truth_d   = truth_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_xfer) begin
          // A new load always begins at bit 0 and invalidates the old shadow.
          shadow_d[0] = wbit_data;
          bit_cnt_d   = CNT_W'(1);
          loaded_d    = 1'b0;
          state_d     = S_LOAD;
          err_d       = start;
        end else if (start) begin
          if (loaded_q) begin
            weight_d = shadow_q;
            truth_d  = 4'd0;
            x_d      = 2'd0;
            settle_d = 4'd0;
            state_d  = S_SWEEP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        err_d = start;
        if (w_xfer) begin
          shadow_d[bit_cnt_q] = wbit_data;
          if (bit_cnt_q == LAST_BIT) begin
            loaded_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      S_SWEEP: begin
        if (settle_q == SETTLE_LAST) begin
          truth_d[x_q] = p_in;
          settle_d     = 4'd0;
          if (x_q == 2'd3) begin
            x_d     = 2'd0;
            state_d = S_DONE;
          end else begin
            x_d = x_q + 2'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_DONE: begin
        // done is registered, so it appears on the cycle after DONE.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_sweep_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perceptron_sweep_controller
//  Purpose  : Randomized scoreboard bench for perceptron_sweep_controller.
//             Two instances (default settle and settle=3) share stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_sweep_controller;

  logic        clk;
  logic        rst;
  logic        wbit_valid;
  logic        wbit_data;
  logic        start;
  logic [3:0]  tbl;

  logic        rdy0, busy0, done0, err0, p0;
  logic [1:0]  x0;
  logic [12:0] w0;
  logic [3:0]  tr0;
  logic        rdy1, busy1, done1, err1, p1;
  logic [1:0]  x1;
  logic [12:0] w1;
  logic [3:0]  tr1;

  // Perceptron stub: p is a combinational lookup of x in the current table.
  assign p0 = tbl[x0];
  assign p1 = tbl[x1];

  perceptron_sweep_controller u_dut (
    .clk(clk), .rst(rst), .wbit_valid(wbit_valid), .wbit_data(wbit_data),
    .wbit_ready(rdy0), .start(start), .busy(busy0), .done(done0), .err(err0),
    .x(x0), .weight(w0), .p_in(p0), .truth(tr0)
  );

  perceptron_sweep_controller #(.WEIGHT_W(13), .SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .wbit_valid(wbit_valid), .wbit_data(wbit_data),
    .wbit_ready(rdy1), .start(start), .busy(busy1), .done(done1), .err(err1),
    .x(x1), .weight(w1), .p_in(p1), .truth(tr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int          t;
    logic [3:0]  truth;
    logic [12:0] weight;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int xcnt0      = 0;
  int xcnt1      = 0;

  // Reference state: what the controller should hold, in plain terms.
  logic [12:0] m_shadow = '0;
  logic [12:0] m_weight = '0;
  logic [3:0]  m_truth  = '0;
  bit          m_loaded = 0;

  function automatic int settle_of(input int id);
    return (id == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wbit_valid && rdy0) xcnt0 <= xcnt0 + 1;
    if (wbit_valid && rdy1) xcnt1 <= xcnt1 + 1;
  end

  // Monitor: pop the expected event whenever a DUT pulses done or err.
  task automatic mon(input int id, input logic d, input logic e,
                     input logic [3:0] tr, input logic [12:0] w);
    ev_t ev;
    int  sz;
    sz = (id == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      if (id == 0) ev = q0[0]; else ev = q1[0];
      if (ev.t < cyc) begin
        vectors++; miscompares++;
        $display("FAIL missing_event dut%0d: expected %s at cycle %0d, not observed by %0d",
                 id, ev.is_done ? "done" : "err", ev.t, cyc);
        if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        sz--;
      end
    end
    if (d || e) begin
      if (sz == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_event dut%0d: done=%b err=%b at cycle %0d, expected none",
                 id, d, e, cyc);
      end else begin
        if (id == 0) ev = q0.pop_front(); else ev = q1.pop_front();
        chk($sformatf("event_kind dut%0d", id), {30'd0, d, e}, ev.is_done ? 32'd2 : 32'd1);
        chk($sformatf("event_cycle dut%0d", id), cyc, ev.t);
        if (ev.is_done) begin
          chk($sformatf("truth dut%0d", id), {28'd0, tr}, {28'd0, ev.truth});
          chk($sformatf("weight_at_done dut%0d", id), {19'd0, w}, {19'd0, ev.weight});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, done0, err0, tr0, w0);
      mon(1, done1, err1, tr1, w1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_err(input int e);
    ev_t ev;
    ev.is_done = 0; ev.t = e; ev.truth = '0; ev.weight = '0;
    q0.push_back(ev);
    q1.push_back(ev);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_shadow = '0; m_weight = '0; m_truth = '0; m_loaded = 0;
  endtask

  // Serially load a word, optionally with random valid gaps and a start
  // request issued alongside one of the bits (always rejected).
  task automatic load_word(input logic [12:0] w, input int gapmax, input int start_bit);
    int c0, c1, gap;
    c0 = xcnt0; c1 = xcnt1;
    for (int i = 0; i < 13; i++) begin
      wbit_valid = 1'b1;
      wbit_data  = w[i];
      if (i == start_bit) begin
        start = 1'b1;
        push_err(cyc + 1);
      end
      tick();
      start = 1'b0;
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      if (gap > 0) begin
        wbit_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    wbit_valid = 1'b0;
    m_shadow = w;
    m_loaded = 1;
    chk("transfer_count dut0", xcnt0 - c0, 32'd13);
    chk("transfer_count dut1", xcnt1 - c1, 32'd13);
  endtask

  // Issue start in IDLE and follow the sweep cycle by cycle.
  task automatic do_start(input bit offer);
    int   e;
    ev_t  ev;
    logic ob;
    e = cyc + 1;
    if (m_loaded) begin
      m_weight = m_shadow;
      m_truth  = tbl;
      for (int id = 0; id < 2; id++) begin
        ev.is_done = 1; ev.truth = tbl; ev.weight = m_shadow;
        ev.t = e + 4 * (settle_of(id) + 1) + 1;
        if (id == 0) q0.push_back(ev); else q1.push_back(ev);
      end
    end else begin
      push_err(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (m_loaded) begin
      chk("weight_after_start dut0", {19'd0, w0}, {19'd0, m_weight});
      chk("weight_after_start dut1", {19'd0, w1}, {19'd0, m_weight});
      ob = 1'($urandom_range(0, 1));
      for (int k = 0; k < 17; k++) begin
        if (k < 8) begin
          chk("x_hold dut0", {30'd0, x0}, k / 2);
          chk("ready_in_sweep dut0", {31'd0, rdy0}, 32'd0);
          chk("busy_in_sweep dut0", {31'd0, busy0}, 32'd1);
        end else if (k == 8) begin
          chk("x_in_done dut0", {30'd0, x0}, 32'd0);
          chk("busy_in_done dut0", {31'd0, busy0}, 32'd1);
        end
        if (k < 16) begin
          chk("x_hold dut1", {30'd0, x1}, k / 4);
          chk("ready_in_sweep dut1", {31'd0, rdy1}, 32'd0);
        end else begin
          chk("x_in_done dut1", {30'd0, x1}, 32'd0);
          chk("busy_in_done dut1", {31'd0, busy1}, 32'd1);
        end
        if (offer) begin
          if (k == 1) begin wbit_valid = 1'b1; wbit_data = ob; end
          if (k == 5) wbit_valid = 1'b0;
          if (k == 2) start = 1'b1;
          if (k == 3) start = 1'b0;
        end
        tick();
      end
      tick();
    end else begin
      tick();
      tick();
    end
    chk("busy_idle dut0", {31'd0, busy0}, 32'd0);
    chk("busy_idle dut1", {31'd0, busy1}, 32'd0);
    chk("weight_idle dut0", {19'd0, w0}, {19'd0, m_weight});
    chk("weight_idle dut1", {19'd0, w1}, {19'd0, m_weight});
    chk("truth_idle dut0", {28'd0, tr0}, {28'd0, m_truth});
    chk("truth_idle dut1", {28'd0, tr1}, {28'd0, m_truth});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [12:0] w;
    int          sb;
    rst = 1'b1; wbit_valid = 1'b0; wbit_data = 1'b0; start = 1'b0; tbl = 4'b1000;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("reset_ready dut0", {31'd0, rdy0}, 32'd1);
    chk("reset_ready dut1", {31'd0, rdy1}, 32'd1);
    chk("reset_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("reset_done_err", {28'd0, done0, err0, done1, err1}, 32'd0);
    chk("reset_x", {28'd0, x0, x1}, 32'd0);
    chk("reset_weight", {6'd0, w0, w1}, 32'd0);
    chk("reset_truth", {24'd0, tr0, tr1}, 32'd0);

    // Start with nothing loaded is rejected.
    do_start(0);

    // Partial load discarded by reset; start is then rejected.
    for (int i = 0; i < 6; i++) begin
      wbit_valid = 1'b1;
      wbit_data  = 1'($urandom_range(0, 1));
      tick();
    end
    wbit_valid = 1'b0;
    do_reset();
    chk("ready_after_reset", {30'd0, rdy0, rdy1}, 32'd3);
    do_start(0);

    // Directed load with valid held high, AND stub, with mid-sweep noise.
    tbl = 4'b1000;
    load_word(13'h1A5B, 0, -1);
    do_start(1);

    // Re-sweep without reloading, XOR stub.
    tbl = 4'b0110;
    do_start(1);

    // Reloading the shadow must not disturb the committed outputs.
    load_word(13'h0000, 2, -1);
    chk("weight_held dut0", {19'd0, w0}, 32'h1A5B);
    chk("weight_held dut1", {19'd0, w1}, 32'h1A5B);
    chk("truth_held dut0", {28'd0, tr0}, 32'h6);
    chk("truth_held dut1", {28'd0, tr1}, 32'h6);
    tbl = 4'($urandom_range(0, 15));
    do_start(0);

    // Same-edge start and first bit: transfer wins, err pulses.
    w = 13'($urandom);
    tbl = 4'($urandom_range(0, 15));
    load_word(w, 1, 0);
    do_start(1);

    // Randomized loads with gaps and occasional start during LOAD.
    for (int n = 0; n < 6; n++) begin
      w   = 13'($urandom);
      tbl = 4'($urandom_range(0, 15));
      sb  = int'($urandom_range(0, 13));
      if (sb == 13) sb = -1;
      load_word(w, 3, sb);
      do_start(n[0]);
    end

    repeat (4) tick();
    chk("queue_empty dut0", q0.size(), 32'd0);
    chk("queue_empty dut1", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
